// File: rtl/cache_arb_pkg.sv
// Shared types for the I/D cache line-memory arbiter.
package cache_arb_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2
   } arb_state_e;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_e;
endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/write-backs onto one line memory.
// One transaction at a time, round-robin on ties, one idle cycle after each completion.
module cache_arbiter
   import cache_arb_pkg::*;
#(
   parameter int LINE_W = 256,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_pmem_read,
   input  logic [ADDR_W-1:0] i_pmem_address,
   output logic [LINE_W-1:0] i_pmem_rdata,
   output logic              i_pmem_resp,
   input  logic              d_pmem_read,
   input  logic              d_pmem_write,
   input  logic [ADDR_W-1:0] d_pmem_address,
   input  logic [LINE_W-1:0] d_pmem_wdata,
   output logic [LINE_W-1:0] d_pmem_rdata,
   output logic              d_pmem_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   arb_state_e        r_state;
   grant_e            r_last_grant;
   logic              r_read;
   logic              r_write;
   logic [ADDR_W-1:0] r_addr;
   logic [LINE_W-1:0] r_wdata;
   logic              w_d_req;
   logic              w_grant_i;

   assign w_d_req   = d_pmem_read | d_pmem_write;
   // On a tie, the side that did not win last time goes first.
   assign w_grant_i = i_pmem_read & (~w_d_req | (r_last_grant == GRANT_D));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_last_grant <= GRANT_I;
         r_read       <= 1'b0;
         r_write      <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant_i) begin
                  r_state      <= I_BUSY;
                  r_last_grant <= GRANT_I;
                  r_read       <= 1'b1;
                  r_write      <= 1'b0;
                  r_addr       <= i_pmem_address;
               end else if (w_d_req) begin
                  // Read+write together resolves to the write-back.
                  r_state      <= D_BUSY;
                  r_last_grant <= GRANT_D;
                  r_read       <= ~d_pmem_write;
                  r_write      <= d_pmem_write;
                  r_addr       <= d_pmem_address;
                  r_wdata      <= d_pmem_wdata;
               end
            end
            I_BUSY, D_BUSY: begin
               if (pmem_resp) begin
                  r_state <= IDLE;
                  r_read  <= 1'b0;
                  r_write <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign pmem_read    = r_read;
   assign pmem_write   = r_write;
   assign pmem_address = r_addr;
   assign pmem_wdata   = r_wdata;

   assign i_pmem_resp  = (r_state == I_BUSY) & pmem_resp;
   assign d_pmem_resp  = (r_state == D_BUSY) & pmem_resp;
   assign i_pmem_rdata = pmem_rdata;
   assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: single grants, tie ordering, latch hold, resets.
module tb_cache_arbiter;
   localparam int LINE_W = 256;
   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              i_pmem_read;
   logic [ADDR_W-1:0] i_pmem_address;
   logic [LINE_W-1:0] i_pmem_rdata;
   logic              i_pmem_resp;
   logic              d_pmem_read;
   logic              d_pmem_write;
   logic [ADDR_W-1:0] d_pmem_address;
   logic [LINE_W-1:0] d_pmem_wdata;
   logic [LINE_W-1:0] d_pmem_rdata;
   logic              d_pmem_resp;
   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [LINE_W-1:0] pmem_wdata;
   logic [LINE_W-1:0] pmem_rdata;
   logic              pmem_resp;

   int total = 0;
   int bad   = 0;

   cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
      .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
      .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
      .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
      .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      i_pmem_read = 0; i_pmem_address = '0;
      d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
      pmem_rdata = '0; pmem_resp = 0;
      #3;
      total++; if (pmem_read !== 1'b0) begin bad++; $display("FAIL rst_read got=%b exp=0", pmem_read); end
      total++; if (pmem_write !== 1'b0) begin bad++; $display("FAIL rst_write got=%b exp=0", pmem_write); end
      total++; if (pmem_address !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", pmem_address); end
      total++; if (pmem_wdata !== '0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", pmem_wdata); end
      total++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin bad++; $display("FAIL rst_resp got=%b exp=00", {i_pmem_resp, d_pmem_resp}); end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_i_read();
      logic [LINE_W-1:0] line;
      line = {32{8'hA5}};
      i_pmem_read = 1; i_pmem_address = 32'h0000_1000;
      tick();
      total++; if ({pmem_read, pmem_write} !== 2'b10) begin bad++; $display("FAIL iread_op got=%b exp=10", {pmem_read, pmem_write}); end
      total++; if (pmem_address !== 32'h1000) begin bad++; $display("FAIL iread_addr got=%h exp=1000", pmem_address); end
      i_pmem_address = 32'h0000_3000;
      tick();
      total++; if (pmem_address !== 32'h1000) begin bad++; $display("FAIL iread_addr_hold got=%h exp=1000", pmem_address); end
      total++; if (i_pmem_resp !== 1'b0) begin bad++; $display("FAIL iread_early_resp got=%b exp=0", i_pmem_resp); end
      tick();
      pmem_rdata = line; pmem_resp = 1;
      #1;
      total++; if (i_pmem_resp !== 1'b1) begin bad++; $display("FAIL iread_resp got=%b exp=1", i_pmem_resp); end
      total++; if (i_pmem_rdata !== line) begin bad++; $display("FAIL iread_rdata got=%h exp=%h", i_pmem_rdata, line); end
      total++; if (d_pmem_resp !== 1'b0) begin bad++; $display("FAIL iread_dresp got=%b exp=0", d_pmem_resp); end
      tick();
      pmem_resp = 0; i_pmem_read = 0; i_pmem_address = '0;
      #1;
      total++; if ({pmem_read, i_pmem_resp} !== 2'b00) begin bad++; $display("FAIL iread_done got=%b exp=00", {pmem_read, i_pmem_resp}); end
      tick();
   endtask

   task automatic test_d_write();
      logic [LINE_W-1:0] line;
      line = {8{32'h1234_5678}};
      d_pmem_write = 1; d_pmem_address = 32'h0000_2020; d_pmem_wdata = line;
      tick();
      total++; if ({pmem_read, pmem_write} !== 2'b01) begin bad++; $display("FAIL dwr_op got=%b exp=01", {pmem_read, pmem_write}); end
      total++; if (pmem_address !== 32'h2020) begin bad++; $display("FAIL dwr_addr got=%h exp=2020", pmem_address); end
      total++; if (pmem_wdata !== line) begin bad++; $display("FAIL dwr_wdata got=%h exp=%h", pmem_wdata, line); end
      // requester drops and scribbles inputs; transaction must carry on unchanged
      d_pmem_write = 0; d_pmem_wdata = '1; d_pmem_address = 32'hFFFF_FFE0;
      tick();
      total++; if ({pmem_write, pmem_address} !== {1'b1, 32'h2020}) begin bad++; $display("FAIL dwr_hold got=%b/%h exp=1/2020", pmem_write, pmem_address); end
      total++; if (pmem_wdata !== line) begin bad++; $display("FAIL dwr_wdata_hold got=%h exp=%h", pmem_wdata, line); end
      pmem_resp = 1;
      #1;
      total++; if ({d_pmem_resp, i_pmem_resp} !== 2'b10) begin bad++; $display("FAIL dwr_resp got=%b exp=10", {d_pmem_resp, i_pmem_resp}); end
      tick();
      pmem_resp = 0; d_pmem_address = '0; d_pmem_wdata = '0;
      #1;
      total++; if (pmem_write !== 1'b0) begin bad++; $display("FAIL dwr_done got=%b exp=0", pmem_write); end
      tick();
   endtask

   task automatic test_rw_both();
      d_pmem_read = 1; d_pmem_write = 1; d_pmem_address = 32'h40;
      tick();
      total++; if ({pmem_read, pmem_write} !== 2'b01) begin bad++; $display("FAIL rw_op got=%b exp=01", {pmem_read, pmem_write}); end
      total++; if (pmem_address !== 32'h40) begin bad++; $display("FAIL rw_addr got=%h exp=40", pmem_address); end
      pmem_resp = 1;
      #1;
      total++; if (d_pmem_resp !== 1'b1) begin bad++; $display("FAIL rw_resp got=%b exp=1", d_pmem_resp); end
      tick();
      pmem_resp = 0; d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0;
      tick();
   endtask

   task automatic test_idle_resp();
      pmem_resp = 1; pmem_rdata = {8{32'hDEAD_BEEF}};
      #1;
      total++; if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin bad++; $display("FAIL idle_resp got=%b exp=00", {i_pmem_resp, d_pmem_resp}); end
      tick();
      pmem_resp = 0;
      total++; if ({pmem_read, pmem_write} !== 2'b00) begin bad++; $display("FAIL idle_op got=%b exp=00", {pmem_read, pmem_write}); end
   endtask

   // After reset both request together: order must be D, I, D, I with an idle gap.
   task automatic test_back_to_back();
      logic [ADDR_W-1:0] exp_addr;
      logic              exp_d;
      rst_n = 0; #2; rst_n = 1;
      tick();
      for (int k = 0; k < 2; k++) begin
         i_pmem_read = 1; i_pmem_address = 32'h600;
         d_pmem_read = 1; d_pmem_address = 32'h500;
         for (int s = 0; s < 2; s++) begin
            exp_d    = (s == 0);
            exp_addr = exp_d ? 32'h500 : 32'h600;
            tick();
            total++; if ({pmem_read, pmem_address} !== {1'b1, exp_addr}) begin bad++; $display("FAIL b2b_grant k=%0d s=%0d got=%b/%h exp=1/%h", k, s, pmem_read, pmem_address, exp_addr); end
            tick();
            pmem_resp = 1;
            #1;
            total++; if ({d_pmem_resp, i_pmem_resp} !== {exp_d, ~exp_d}) begin bad++; $display("FAIL b2b_resp k=%0d s=%0d got=%b exp=%b", k, s, {d_pmem_resp, i_pmem_resp}, {exp_d, ~exp_d}); end
            tick();
            pmem_resp = 0;
            if (exp_d) d_pmem_read = 0; else i_pmem_read = 0;
            #1;
            total++; if (pmem_read !== 1'b0) begin bad++; $display("FAIL b2b_idle k=%0d s=%0d got=%b exp=0", k, s, pmem_read); end
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      d_pmem_write = 1; d_pmem_address = 32'h2020; d_pmem_wdata = {8{32'hCAFE_F00D}};
      tick();
      total++; if (pmem_write !== 1'b1) begin bad++; $display("FAIL rmid_granted got=%b exp=1", pmem_write); end
      #2; rst_n = 0; #1;
      total++; if ({pmem_write, pmem_address} !== {1'b0, 32'h0}) begin bad++; $display("FAIL rmid_drop got=%b/%h exp=0/0", pmem_write, pmem_address); end
      d_pmem_write = 0;
      tick();
      rst_n = 1;
      pmem_resp = 1;
      #1;
      total++; if (d_pmem_resp !== 1'b0) begin bad++; $display("FAIL rmid_resp got=%b exp=0", d_pmem_resp); end
      tick();
      pmem_resp = 0;
      i_pmem_read = 1; i_pmem_address = 32'h700;
      tick();
      total++; if ({pmem_read, pmem_address} !== {1'b1, 32'h700}) begin bad++; $display("FAIL rmid_idle got=%b/%h exp=1/700", pmem_read, pmem_address); end
      pmem_resp = 1;
      tick();
      pmem_resp = 0; i_pmem_read = 0;
      tick();
   endtask

   initial begin
      test_reset();
      test_i_read();
      test_d_write();
      test_rw_both();
      test_idle_resp();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout total=%0d", total);
      $fatal(1, "timeout");
   end
endmodule
